// File: rtl/arm_pipe_pkg.sv
// Shared encodings for the ARM pipeline control path: ALU op codes, instruction
// field values, condition codes, forwarding selects and the per-stage control bundles.
package arm_pipe_pkg;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_ORR = 4'h3;
   localparam logic [3:0] ALU_EOR = 4'h4;
   localparam logic [3:0] ALU_MOV = 4'h5;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_t;

   typedef enum logic [1:0] {
      FWD_RD1E    = 2'b00,
      FWD_RESULTW = 2'b01,
      FWD_ALUOUTM = 2'b10
   } fwd_t;

   typedef struct packed {
      logic       pc_src;
      logic       reg_w;
      logic       mem_to_reg;
      logic       mem_w;
      logic       branch;
      logic       flag_w;
      logic       alu_src;
      logic [3:0] alu_ctl;
      logic [3:0] cond;
   } ctrl_t;

   typedef struct packed {
      logic pc_src;
      logic reg_w;
      logic mem_to_reg;
      logic mem_w;
   } mstage_t;

   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      cond_holds = 1'b0;
      case (cond_t'(cond))
         COND_EQ: cond_holds = z;
         COND_NE: cond_holds = ~z;
         COND_CS: cond_holds = c;
         COND_CC: cond_holds = ~c;
         COND_MI: cond_holds = n;
         COND_PL: cond_holds = ~n;
         COND_VS: cond_holds = v;
         COND_VC: cond_holds = ~v;
         COND_HI: cond_holds = c & ~z;
         COND_LS: cond_holds = ~c | z;
         COND_GE: cond_holds = (n == v);
         COND_LT: cond_holds = (n != v);
         COND_GT: cond_holds = ~z & (n == v);
         COND_LE: cond_holds = z | (n != v);
         COND_AL: cond_holds = 1'b1;
         COND_NV: cond_holds = 1'b0;
         default: cond_holds = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register and execute-stage condition evaluation.
// Flags only update when the flag-setting instruction actually executes.
module cond_unit
   import arm_pipe_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_e,
   input  logic       flag_we,
   input  logic [3:0] alu_flags,
   output logic       cond_ex
);

   logic [3:0] flags_d;
   logic [3:0] flags_q;

   assign cond_ex = cond_holds(cond_e, flags_q);

   always_comb begin
      flags_d = flags_q;
      if (flag_we & cond_ex) flags_d = alu_flags;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) flags_q <= FLAGS_RESET;
      else       flags_q <= flags_d;
   end

endmodule

// File: rtl/pipeline_controller.sv
// Control path for the 5-stage ARM pipeline: decode, D->E->M->W control registers,
// condition execution and hazard resolution (forwarding, stalls, flushes).
module pipeline_controller
   import arm_pipe_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] InstrD,
   input  logic [3:0]  ALUFlags,
   input  logic [4:0]  match,
   output logic [1:0]  RegSrcD,
   output logic [1:0]  ImmSrcD,
   output logic        ALUSrcE,
   output logic [3:0]  ALUControlE,
   output logic        BranchTakenE,
   output logic        MemWriteM,
   output logic        MemtoRegW,
   output logic        RegWriteW,
   output logic        PCSrcW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        stallF,
   output logic        stallD,
   output logic        flushD,
   output logic        flushE
);

   logic [3:0] cond_d;
   logic [1:0] op_d;
   logic [5:0] funct_d;
   logic [3:0] rd_d;
   logic       unused_rn;

   ctrl_t      dec_ctrl;
   logic [1:0] reg_src_dec;
   logic [1:0] imm_src_dec;

   ctrl_t      ctrl_e_d, ctrl_e_q;
   mstage_t    stage_m_d, stage_m_q;
   logic       reg_write_w_d, reg_write_w_q;
   logic       mem_to_reg_w_d, mem_to_reg_w_q;
   logic       pc_src_w_d, pc_src_w_q;

   logic       run;
   logic       cond_ex_e;
   logic       branch_taken_e;
   logic       ldr_stall;
   logic       pc_wr_pend;
   logic       flush_e_int;
   fwd_t       fwd_a, fwd_b;

   assign run       = ~reset;
   assign cond_d    = InstrD[19:16];
   assign op_d      = InstrD[15:14];
   assign funct_d   = InstrD[13:8];
   assign rd_d      = InstrD[3:0];
   assign unused_rn = ^InstrD[7:4];

   // funct_d = {I, cmd[3:0], S} for data-processing; funct_d[0] is L for memory ops
   always_comb begin
      dec_ctrl         = '0;
      reg_src_dec      = 2'b00;
      imm_src_dec      = 2'b00;
      dec_ctrl.cond    = cond_d;
      dec_ctrl.alu_ctl = ALU_ADD;
      case (op_d)
         OP_DP: begin
            dec_ctrl.reg_w   = 1'b1;
            dec_ctrl.alu_src = funct_d[5];
            dec_ctrl.flag_w  = funct_d[0];
            case (funct_d[4:1])
               CMD_ADD: dec_ctrl.alu_ctl = ALU_ADD;
               CMD_SUB: dec_ctrl.alu_ctl = ALU_SUB;
               CMD_AND: dec_ctrl.alu_ctl = ALU_AND;
               CMD_ORR: dec_ctrl.alu_ctl = ALU_ORR;
               CMD_EOR: dec_ctrl.alu_ctl = ALU_EOR;
               CMD_MOV: dec_ctrl.alu_ctl = ALU_MOV;
               CMD_CMP: begin
                  dec_ctrl.alu_ctl = ALU_SUB;
                  dec_ctrl.reg_w   = 1'b0;
               end
               default: dec_ctrl.alu_ctl = ALU_ADD;
            endcase
         end
         OP_MEM: begin
            dec_ctrl.alu_src = 1'b1;
            imm_src_dec      = 2'b01;
            if (funct_d[0]) begin
               dec_ctrl.mem_to_reg = 1'b1;
               dec_ctrl.reg_w      = 1'b1;
            end else begin
               dec_ctrl.mem_w = 1'b1;
               reg_src_dec[1] = 1'b1;
            end
         end
         OP_BR: begin
            dec_ctrl.branch  = 1'b1;
            dec_ctrl.alu_src = 1'b1;
            imm_src_dec      = 2'b10;
            reg_src_dec[0]   = 1'b1;
         end
         default: ;
      endcase
      dec_ctrl.pc_src = dec_ctrl.reg_w & (rd_d == 4'hF);
   end

   cond_unit #(
      .FLAGS_RESET (FLAGS_RESET)
   ) u_cond_unit (
      .clk       (clk),
      .reset     (reset),
      .cond_e    (ctrl_e_q.cond),
      .flag_we   (ctrl_e_q.flag_w),
      .alu_flags (ALUFlags),
      .cond_ex   (cond_ex_e)
   );

   assign branch_taken_e = ctrl_e_q.branch & cond_ex_e;

   always_comb begin
      ctrl_e_d = dec_ctrl;
      if (flush_e_int) ctrl_e_d = '0;
   end

   // Instructions that fail their condition leave M with every enable cleared
   always_comb begin
      stage_m_d.pc_src     = ctrl_e_q.pc_src & cond_ex_e;
      stage_m_d.reg_w      = ctrl_e_q.reg_w & cond_ex_e;
      stage_m_d.mem_w      = ctrl_e_q.mem_w & cond_ex_e;
      stage_m_d.mem_to_reg = ctrl_e_q.mem_to_reg;
      reg_write_w_d        = stage_m_q.reg_w;
      mem_to_reg_w_d       = stage_m_q.mem_to_reg;
      pc_src_w_d           = stage_m_q.pc_src;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_e_q       <= '0;
         stage_m_q      <= '0;
         reg_write_w_q  <= 1'b0;
         mem_to_reg_w_q <= 1'b0;
         pc_src_w_q     <= 1'b0;
      end else begin
         ctrl_e_q       <= ctrl_e_d;
         stage_m_q      <= stage_m_d;
         reg_write_w_q  <= reg_write_w_d;
         mem_to_reg_w_q <= mem_to_reg_w_d;
         pc_src_w_q     <= pc_src_w_d;
      end
   end

   always_comb begin
      fwd_a = FWD_RD1E;
      fwd_b = FWD_RD1E;
      if (match[3] & stage_m_q.reg_w)   fwd_a = FWD_ALUOUTM;
      else if (match[1] & reg_write_w_q) fwd_a = FWD_RESULTW;
      if (match[2] & stage_m_q.reg_w)   fwd_b = FWD_ALUOUTM;
      else if (match[0] & reg_write_w_q) fwd_b = FWD_RESULTW;
   end

   // Decode-derived terms are masked while reset is held so every output reads 0
   assign ldr_stall   = (match[4] != 1'b0) & ctrl_e_q.mem_to_reg;
   assign pc_wr_pend  = run & (dec_ctrl.pc_src | ctrl_e_q.pc_src | stage_m_q.pc_src);
   assign flush_e_int = ldr_stall | branch_taken_e;

   assign RegSrcD      = run ? reg_src_dec : 2'b00;
   assign ImmSrcD      = run ? imm_src_dec : 2'b00;
   assign ALUSrcE      = ctrl_e_q.alu_src;
   assign ALUControlE  = ctrl_e_q.alu_ctl;
   assign BranchTakenE = branch_taken_e;
   assign MemWriteM    = stage_m_q.mem_w;
   assign MemtoRegW    = mem_to_reg_w_q;
   assign RegWriteW    = reg_write_w_q;
   assign PCSrcW       = pc_src_w_q;
   assign ForwardAE    = fwd_a;
   assign ForwardBE    = fwd_b;
   assign stallF       = ldr_stall | pc_wr_pend;
   assign stallD       = ldr_stall;
   assign flushD       = pc_wr_pend | pc_src_w_q | branch_taken_e;
   assign flushE       = flush_e_int;

endmodule
